lite_irq_ctrl: RTL and testbench
================================

LITE_IRQ_CTRL -- requirements
Module: lite_irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 4, giving the number of event sources (range 1..8).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte base of a 32-byte register window.
REQ-003 SHALL have port user_clk  input  1  the single clock; all logic is in this domain.
REQ-004 SHALL have port user_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port user_wren  input  1  register write strobe.
REQ-006 SHALL have port user_wstrb  input  4  byte enables for user_wren.
REQ-007 SHALL have port user_rden  input  1  register read strobe.
REQ-008 SHALL have port user_addr  input  32  byte address.
REQ-009 SHALL have port user_wr_data  input  32  write data.
REQ-010 SHALL have port user_rd_data  output  32  read data, registered.
REQ-011 SHALL have port user_irq  output  1  single-cycle interrupt pulse to host.
REQ-012 SHALL have port src_event  input  NSRC  level event inputs, synchronous to user_clk.

Function
REQ-013 Block selected when user_addr[31:5]==BASE_ADDR[31:5]; register index = user_addr[4:2]; unselected or unmapped reads return 0, writes ignored.
REQ-014 Registers: 0x00 PENDING (R/W1C), 0x04 MASK (RW), 0x08 VECTOR (R, claim-on-read), 0x0C OVERRUN (R/W1C), 0x10 CONTROL (RW: bit0 ENABLE, bits[15:8] HOLDOFF). Unimplemented bits read 0.
REQ-015 Writes honour user_wstrb per byte; write takes effect on the clock edge where user_wren=1.
REQ-016 Read latency exactly 1: user_rd_data holds the value sampled at the user_rden cycle from the next edge onward; it holds until the next read.
REQ-017 Rising edge on src_event[i] (registered copy 0, current 1) sets PENDING[i]; if PENDING[i] was already 1, OVERRUN[i] is also set.
REQ-018 Same-cycle set and clear (W1C or claim) on one bit: set wins.
REQ-019 VECTOR = {valid, 27'b0, idx[3:0]}: valid=|(PENDING&MASK); idx = first set bit of PENDING&MASK searched round-robin from pointer RRP upward, wrapping at NSRC.
REQ-020 VECTOR read with valid=1 clears PENDING[idx] and sets RRP to (idx+1) mod NSRC in the same edge; with valid=0 there is no side effect.
REQ-021 IRQ FSM states: IDLE, PULSE, HOLD. IDLE->PULSE when ENABLE & valid & REARM; PULSE lasts exactly one cycle with user_irq=1, clears REARM, and loads CNT=HOLDOFF; HOLD decrements CNT and goes to IDLE on the cycle CNT==0.
REQ-022 REARM is set by any masked-in new edge, any VECTOR claim, or any PENDING W1C write; it is cleared only in PULSE, and a set in the same cycle as PULSE wins.
REQ-023 Clearing ENABLE in HOLD does not abort HOLD; further pulses are suppressed until ENABLE=1.
REQ-024 user_irq SHALL be 1 only in PULSE (registered output).

Reset
REQ-025 On user_rst=1, asynchronously: PENDING, MASK, OVERRUN, CONTROL, RRP, CNT, REARM, the src_event register and user_rd_data SHALL be 0; FSM SHALL be IDLE; user_irq SHALL be 0.
REQ-026 A source already high when reset releases counts as a rising edge on the first clock.
REQ-027 Reset asserted mid-PULSE/HOLD forces IDLE with no residual pulse.

Structure
REQ-028 A shared package lite_irq_pkg SHALL hold the register offsets, CONTROL field positions, the FSM state enum and NSRC_MAX=8.
REQ-029 The round-robin search SHALL be a combinational sub-module lite_irq_rr_pick (request vector and pointer in; valid and index out).

Verification
REQ-030 Reset release with src_event=4'b0000, MASK=4'hF, ENABLE=1, then a pulse on src_event[2] -> PENDING=4'b0100, user_irq high exactly 1 cycle, 3 cycles after the edge or fewer.
REQ-031 Read VECTOR with PENDING=4'b1010, RRP=0 -> returns 0x8000_0001; the second read returns 0x8000_0003; the third read returns 0x0000_0000; PENDING ends at 0.
REQ-032 HOLDOFF=5, two events 2 cycles apart with a claim in between -> the second user_irq pulse occurs no earlier than 6 cycles after the first.
REQ-033 Two edges on src_event[0] without a clear -> OVERRUN=4'b0001; W1C 0x1 to OVERRUN in the same cycle as a third edge -> OVERRUN stays 1.
REQ-034 Write to MASK with user_wstrb=4'b0001 and data 0xFFFF_FF05 -> MASK=0x05; a read at BASE_ADDR+0x1C -> returns 0.
REQ-035 Assert user_rst during HOLD with PENDING nonzero -> all registers 0, user_irq 0, no pulse until new edges occur.

Source files
------------

// File: rtl/lite_irq_pkg.sv
// lite_irq_pkg: shared constants and types for the lite interrupt controller.
//   Register byte offsets and their word indices, CONTROL field positions,
//   IRQ FSM state encoding, and the maximum source count.
package lite_irq_pkg;

  localparam int NSRC_MAX = 8;

  localparam logic [4:0] OFS_PENDING = 5'h00;
  localparam logic [4:0] OFS_MASK    = 5'h04;
  localparam logic [4:0] OFS_VECTOR  = 5'h08;
  localparam logic [4:0] OFS_OVERRUN = 5'h0C;
  localparam logic [4:0] OFS_CONTROL = 5'h10;

  // word index as decoded from addr[4:2]
  localparam logic [2:0] IDX_PENDING = OFS_PENDING[4:2];
  localparam logic [2:0] IDX_MASK    = OFS_MASK[4:2];
  localparam logic [2:0] IDX_VECTOR  = OFS_VECTOR[4:2];
  localparam logic [2:0] IDX_OVERRUN = OFS_OVERRUN[4:2];
  localparam logic [2:0] IDX_CONTROL = OFS_CONTROL[4:2];

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_HOLD_LSB = 8;
  localparam int CTRL_HOLD_MSB = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_HOLD
  } irq_state_e;

  // VECTOR register image: {valid, 27'b0, idx[3:0]}
  function automatic logic [31:0] vector_word(input logic valid, input logic [2:0] idx);
    return {valid, 27'b0, 1'b0, idx};
  endfunction

endpackage

// File: rtl/lite_irq_ctrl_if.sv
// lite_irq_ctrl_if: register-bus bundle for the lite interrupt controller.
//   wren/wstrb/rden/addr/wr_data : host -> controller
//   rd_data/irq                  : controller -> host
// The controller top keeps flat user_* ports; this bundle groups the same
// signals on the host side so an agent can drive them through a modport.
interface lite_irq_ctrl_if;
  logic        wren;
  logic [3:0]  wstrb;
  logic        rden;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  modport master (output wren, wstrb, rden, addr, wr_data, input rd_data, irq);
  modport slave  (input wren, wstrb, rden, addr, wr_data, output rd_data, irq);
endinterface

// File: rtl/lite_irq_rr_pick.sv
// lite_irq_rr_pick: combinational round-robin picker.
//   req_i   : request vector (NSRC bits)
//   ptr_i   : search start position, must be < NSRC
//   valid_o : any request set
//   idx_o   : first set request at or after ptr_i, wrapping at NSRC
module lite_irq_rr_pick import lite_irq_pkg::*; #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic            valid_o,
  output logic [2:0]      idx_o
);

  localparam logic [3:0] N4 = 4'(NSRC);

  logic [NSRC_MAX-1:0] req_pad;
  logic [3:0]          pos;

  // Walk offsets from farthest to nearest so the last hit kept is the
  // closest one to the pointer.
  always_comb begin
    req_pad = '0;
    req_pad[NSRC-1:0] = req_i;
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + 4'(k);
      if (pos >= N4) pos = pos - N4;
      if (req_pad[pos[2:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/lite_irq_ctrl.sv
// lite_irq_ctrl: event-to-interrupt controller with a 32-byte register window.
//   user_clk/user_rst      : clock, async active-high reset
//   user_wren/wstrb/rden   : register write (byte enables) / read strobes
//   user_addr/user_wr_data : byte address / write data
//   user_rd_data           : registered read data, 1-cycle latency, holds
//   user_irq               : single-cycle interrupt pulse
//   src_event              : level event inputs, rising edges latch PENDING
// Registers: PENDING W1C, MASK RW, VECTOR claim-on-read, OVERRUN W1C,
// CONTROL {HOLDOFF[15:8], ENABLE[0]}.
module lite_irq_ctrl import lite_irq_pkg::*; #(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            user_clk,
  input  logic            user_rst,
  input  logic            user_wren,
  input  logic [3:0]      user_wstrb,
  input  logic            user_rden,
  input  logic [31:0]     user_addr,
  input  logic [31:0]     user_wr_data,
  output logic [31:0]     user_rd_data,
  output logic            user_irq,
  input  logic [NSRC-1:0] src_event
);

  localparam logic [3:0] N4 = 4'(NSRC);

  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, ovr_q, ovr_d, src_q;
  logic [NSRC-1:0] rise, req, claim_oh, pend_clr, ovr_clr;
  logic            en_q, en_d, rearm_q, rearm_set, irq_q;
  logic [7:0]      hold_q, hold_d, cnt_q;
  logic [2:0]      rrp_q, rrp_d, pidx, ridx;
  logic [3:0]      rrp_nxt;
  logic [31:0]     rd_q, rd_val;
  logic            sel, vld, claim;
  logic            wr_pend, wr_mask, wr_ovr, wr_ctrl, rd_vec;
  irq_state_e      st_q;

  // address bits [1:0], upper data and strobes only partly matter
  logic unused_bits;
  assign unused_bits = ^{user_addr[1:0], user_wr_data, user_wstrb};

  assign sel  = (user_addr[31:5] == BASE_ADDR[31:5]);
  assign ridx = user_addr[4:2];

  assign wr_pend = user_wren & sel & (ridx == IDX_PENDING);
  assign wr_mask = user_wren & sel & (ridx == IDX_MASK);
  assign wr_ovr  = user_wren & sel & (ridx == IDX_OVERRUN);
  assign wr_ctrl = user_wren & sel & (ridx == IDX_CONTROL);
  assign rd_vec  = user_rden & sel & (ridx == IDX_VECTOR);

  assign rise = src_event & ~src_q;
  assign req  = pend_q & mask_q;

  lite_irq_rr_pick #(.NSRC(NSRC)) u_pick (
    .req_i   (req),
    .ptr_i   (rrp_q),
    .valid_o (vld),
    .idx_o   (pidx)
  );

  assign claim    = rd_vec & vld;
  assign claim_oh = claim ? (NSRC'(1) << pidx) : '0;
  assign rrp_nxt  = {1'b0, pidx} + 4'd1;

  // Sources sit in byte 0, so only wstrb[0] gates the per-source registers.
  // Set terms are OR-ed in last so a same-edge set beats any clear.
  always_comb begin
    pend_clr = ((wr_pend && user_wstrb[0]) ? user_wr_data[NSRC-1:0] : '0) | claim_oh;
    ovr_clr  = (wr_ovr && user_wstrb[0]) ? user_wr_data[NSRC-1:0] : '0;
    pend_d   = (pend_q & ~pend_clr) | rise;
    ovr_d    = (ovr_q & ~ovr_clr) | (rise & pend_q);
    mask_d   = (wr_mask && user_wstrb[0]) ? user_wr_data[NSRC-1:0] : mask_q;
    en_d     = (wr_ctrl && user_wstrb[0]) ? user_wr_data[CTRL_EN_BIT] : en_q;
    hold_d   = (wr_ctrl && user_wstrb[1]) ? user_wr_data[CTRL_HOLD_MSB:CTRL_HOLD_LSB] : hold_q;
    rrp_d    = rrp_q;
    if (claim) rrp_d = (rrp_nxt >= N4) ? 3'd0 : rrp_nxt[2:0];
  end

  assign rearm_set = (|(rise & mask_q)) | claim | wr_pend;

  always_comb begin
    rd_val = '0;
    if (sel) begin
      case (ridx)
        IDX_PENDING: rd_val = 32'(pend_q);
        IDX_MASK:    rd_val = 32'(mask_q);
        IDX_VECTOR:  rd_val = vector_word(vld, pidx);
        IDX_OVERRUN: rd_val = 32'(ovr_q);
        IDX_CONTROL: rd_val = {16'b0, hold_q, 7'b0, en_q};
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      pend_q  <= '0;
      mask_q  <= '0;
      ovr_q   <= '0;
      src_q   <= '0;
      en_q    <= 1'b0;
      hold_q  <= '0;
      rrp_q   <= '0;
      rearm_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      ovr_q   <= ovr_d;
      src_q   <= src_event;
      en_q    <= en_d;
      hold_q  <= hold_d;
      rrp_q   <= rrp_d;
      // a fresh arming reason in the PULSE cycle survives the clear
      rearm_q <= rearm_set | (rearm_q & (st_q != ST_PULSE));
      if (user_rden) rd_q <= rd_val;
    end
  end

  // HOLD runs out even if ENABLE drops; the IDLE check gates new pulses.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (st_q)
        ST_IDLE: if (en_q && vld && rearm_q) begin
          st_q  <= ST_PULSE;
          irq_q <= 1'b1;
        end
        ST_PULSE: begin
          st_q  <= ST_HOLD;
          cnt_q <= hold_q;
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) st_q <= ST_IDLE;
          else               cnt_q <= cnt_q - 8'd1;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign user_rd_data = rd_q;
  assign user_irq     = irq_q;

endmodule

// File: tb/tb_lite_irq_ctrl.sv
// tb_lite_irq_ctrl: directed table + hand sequences for lite_irq_ctrl.
module tb_lite_irq_ctrl;
  import lite_irq_pkg::*;

  localparam int NSRC = 4;

  logic            user_clk = 1'b0;
  logic            user_rst;
  logic [NSRC-1:0] src_event;

  lite_irq_ctrl_if bus();

  lite_irq_ctrl #(.NSRC(NSRC), .BASE_ADDR(32'h0000_0000)) dut (
    .user_clk     (user_clk),
    .user_rst     (user_rst),
    .user_wren    (bus.wren),
    .user_wstrb   (bus.wstrb),
    .user_rden    (bus.rden),
    .user_addr    (bus.addr),
    .user_wr_data (bus.wr_data),
    .user_rd_data (bus.rd_data),
    .user_irq     (bus.irq),
    .src_event    (src_event)
  );

  always #5 user_clk = ~user_clk;

  localparam logic [31:0] A_PEND = 32'(OFS_PENDING);
  localparam logic [31:0] A_MASK = 32'(OFS_MASK);
  localparam logic [31:0] A_VEC  = 32'(OFS_VECTOR);
  localparam logic [31:0] A_OVR  = 32'(OFS_OVERRUN);
  localparam logic [31:0] A_CTRL = 32'(OFS_CONTROL);

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int irq_q[$];
  int wide_cnt = 0;
  logic prev_irq = 1'b0;

  always @(posedge user_clk) cyc++;

  // irq seen mid-cycle; two consecutive highs means a stretched pulse
  always @(negedge user_clk) begin
    if (bus.irq === 1'b1) begin
      irq_q.push_back(cyc);
      if (prev_irq) wide_cnt++;
    end
    prev_irq = (bus.irq === 1'b1);
  end

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // all bus tasks start and end on a falling edge
  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wren = 1'b1; bus.addr = a; bus.wr_data = d; bus.wstrb = s;
    @(negedge user_clk);
    bus.wren = 1'b0; bus.wstrb = 4'h0;
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [31:0] d);
    bus.rden = 1'b1; bus.addr = a;
    @(posedge user_clk);
    #1 d = bus.rd_data;
    @(negedge user_clk);
    bus.rden = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    do_rd(a, v);
    chk(nm, v, exp);
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    src_event = m;
    @(negedge user_clk);
    src_event = '0;
    @(negedge user_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge user_clk);
  endtask

  initial begin
    int b, c0, lat, gap;

    bus.wren = 1'b0; bus.rden = 1'b0; bus.wstrb = 4'h0;
    bus.addr = '0; bus.wr_data = '0; src_event = '0;
    user_rst = 1'b1;
    idle(3);
    chk("rst_rd_data", bus.rd_data, 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    user_rst = 1'b0;
    idle(1);

    // register access table
    vt.push_back('{1'b0, A_PEND, 32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b0, A_MASK, 32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b0, A_VEC,  32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b0, A_OVR,  32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b1, A_MASK, 32'hFFFF_FF05, 4'h1, 32'h0});
    vt.push_back('{1'b0, A_MASK, 32'h0, 4'h0, 32'h5});
    vt.push_back('{1'b1, A_MASK, 32'hFFFF_FFFF, 4'hE, 32'h0});
    vt.push_back('{1'b0, A_MASK, 32'h0, 4'h0, 32'h5});
    vt.push_back('{1'b0, 32'h1C, 32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b1, 32'h24, 32'hF, 4'hF, 32'h0});
    vt.push_back('{1'b0, A_MASK, 32'h0, 4'h0, 32'h5});
    vt.push_back('{1'b0, 32'h24, 32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b1, A_CTRL, 32'h0000_0301, 4'h1, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 4'h0, 32'h1});
    vt.push_back('{1'b1, A_CTRL, 32'hFFFF_0500, 4'h2, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 4'h0, 32'h501});
    vt.push_back('{1'b1, A_CTRL, 32'hFFFF_FFFE, 4'hF, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 4'h0, 32'hFF00});
    vt.push_back('{1'b1, A_CTRL, 32'h0, 4'hF, 32'h0});
    vt.push_back('{1'b0, A_CTRL, 32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b1, A_MASK, 32'hF, 4'h1, 32'h0});
    vt.push_back('{1'b0, 32'h14, 32'h0, 4'h0, 32'h0});
    vt.push_back('{1'b0, A_MASK, 32'h0, 4'h0, 32'hF});

    foreach (vt[i]) begin
      if (vt[i].is_wr) do_wr(vt[i].addr, vt[i].data, vt[i].strb);
      else rd_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
    end

    // read data holds across non-read cycles
    do_wr(A_MASK, 32'h0, 4'h1);
    idle(2);
    chk("rd_hold", bus.rd_data, 32'hF);
    do_wr(A_MASK, 32'hF, 4'h1);

    // single event -> one short-latency pulse
    do_wr(A_CTRL, 32'h1, 4'h1);
    b = irq_q.size(); c0 = cyc;
    pulse(4'b0100);
    idle(6);
    chk("irq1_cnt", 32'(irq_q.size() - b), 32'd1);
    lat = (irq_q.size() > b) ? irq_q[b] - c0 : 99;
    chk("irq1_lat_le3", 32'(lat >= 1 && lat <= 3), 32'd1);
    rd_chk("pend_0100", A_PEND, 32'h4);
    rd_chk("claim_2", A_VEC, 32'h8000_0002);
    do_wr(A_CTRL, 32'h0, 4'h1);

    // round-robin claims; first bring the pointer back to 0
    pulse(4'b1000);
    rd_chk("claim_3_wrap", A_VEC, 32'h8000_0003);
    pulse(4'b1010);
    rd_chk("rr_claim1", A_VEC, 32'h8000_0001);
    rd_chk("rr_claim2", A_VEC, 32'h8000_0003);
    rd_chk("rr_claim3", A_VEC, 32'h0);
    rd_chk("rr_pend_end", A_PEND, 32'h0);
    rd_chk("rr_ovr_none", A_OVR, 32'h0);

    // overrun, set-beats-clear, strobe gating
    pulse(4'b0001);
    pulse(4'b0001);
    rd_chk("ovr_set", A_OVR, 32'h1);
    src_event = 4'b0001;
    do_wr(A_OVR, 32'h1, 4'h1);
    src_event = '0;
    idle(1);
    rd_chk("ovr_set_wins", A_OVR, 32'h1);
    src_event = 4'b0001;
    do_wr(A_PEND, 32'h1, 4'h1);
    src_event = '0;
    idle(1);
    rd_chk("pend_set_wins", A_PEND, 32'h1);
    do_wr(A_OVR, 32'h1, 4'h0);
    rd_chk("ovr_no_strb", A_OVR, 32'h1);
    do_wr(A_OVR, 32'hF, 4'h1);
    rd_chk("ovr_w1c", A_OVR, 32'h0);
    do_wr(A_PEND, 32'hF, 4'h1);
    rd_chk("pend_w1c", A_PEND, 32'h0);

    // holdoff spacing between two pulses
    do_wr(A_CTRL, 32'h0000_0501, 4'h3);
    b = irq_q.size();
    pulse(4'b0010);
    rd_chk("hold_claim", A_VEC, 32'h8000_0001);
    pulse(4'b0100);
    idle(25);
    chk("hold_cnt", 32'(irq_q.size() - b), 32'd2);
    gap = (irq_q.size() >= b + 2) ? irq_q[b+1] - irq_q[b] : 0;
    chk("hold_gap_ge6", 32'(gap >= 6), 32'd1);
    rd_chk("hold_pend", A_PEND, 32'h4);

    // reset during HOLD with PENDING and OVERRUN nonzero
    b = irq_q.size();
    pulse(4'b0100);
    idle(1);
    chk("pre_rst_pulse", 32'(irq_q.size() - b), 32'd1);
    user_rst = 1'b1;
    #1;
    chk("rst_async_irq", 32'(bus.irq), 32'h0);
    chk("rst_async_rd", bus.rd_data, 32'h0);
    idle(2);
    user_rst = 1'b0;
    b = irq_q.size();
    idle(10);
    chk("post_rst_no_irq", 32'(irq_q.size() - b), 32'd0);
    rd_chk("post_rst_pend", A_PEND, 32'h0);
    rd_chk("post_rst_mask", A_MASK, 32'h0);
    rd_chk("post_rst_ovr", A_OVR, 32'h0);
    rd_chk("post_rst_ctrl", A_CTRL, 32'h0);
    rd_chk("post_rst_vec", A_VEC, 32'h0);
    do_wr(A_MASK, 32'hF, 4'h1);
    do_wr(A_CTRL, 32'h1, 4'h1);
    idle(6);
    chk("post_rst_quiet", 32'(irq_q.size() - b), 32'd0);

    // source held high across reset release registers as an edge
    src_event = 4'b0001;
    user_rst = 1'b1;
    idle(2);
    user_rst = 1'b0;
    idle(3);
    rd_chk("rst_edge_pend", A_PEND, 32'h1);
    src_event = '0;

    chk("irq_single_cycle", 32'(wide_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
